// File: rtl/dev_fs_responder_pkg.sv
// Shared path constants, open-file encodings and name decoding for the
// filesystem responder.
package dev_fs_responder_pkg;

    localparam logic [31:0] PATH_DEV  = 32'h2F646576;
    localparam logic [31:0] PATH_MEM  = 32'h2F6D656D;
    localparam logic [31:0] PATH_META = 32'h6D657461;

    typedef enum logic [1:0] {
        OPEN_NONE = 2'd0,
        OPEN_MEM  = 2'd1,
        OPEN_META = 2'd2
    } open_e;

    typedef enum logic {
        NAME_IDLE,
        NAME_COLLECT
    } name_state_e;

    // Only exact two- or three-chunk names resolve; an overflowed buffer never does.
    function automatic open_e decode_name(input logic [31:0] c0,
                                          input logic [31:0] c1,
                                          input logic [31:0] c2,
                                          input logic [2:0]  cnt,
                                          input logic        ovf);
        open_e r;
        r = OPEN_NONE;
        if (!ovf && cnt == 3'd2 && c0 == PATH_DEV && c1 == PATH_MEM)
            r = OPEN_MEM;
        else if (!ovf && cnt == 3'd3 && c0 == PATH_DEV && c1 == PATH_MEM && c2 == PATH_META)
            r = OPEN_META;
        return r;
    endfunction

endpackage

// File: rtl/dev_fs_responder_ram.sv
// Single-port synchronous RAM with separate read enable; a read in the same
// cycle as a write returns the old contents.
module dev_fs_responder_ram #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          a_rd,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_q
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (a_we)
            mem[a_addr] <= a_wdata;
        if (a_rd)
            a_q <= mem[a_addr];
    end

endmodule

// File: rtl/dev_fs_responder.sv
// Filesystem-port responder: decodes a chunked filename into /dev/mem or
// /dev/memmeta and services word reads/writes against the opened store.
module dev_fs_responder
    import dev_fs_responder_pkg::*;
#(
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned META_AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fsAccess,
    input  logic [31:0] fsFilename,
    input  logic        fsRden,
    input  logic        fsWren,
    input  logic [31:0] fsAddress,
    input  logic [31:0] fsData,
    output logic [31:0] fsQ,
    output logic [1:0]  openFile,
    output logic        nameErr,
    output logic        rangeErr
);

    name_state_e state, state_next;
    logic [31:0] chunk [4];
    logic [2:0]  cnt;
    logic        ovf;
    logic        close;
    open_e       open_q, open_next;

    logic        acc_rd, acc_wr;
    logic        mem_ok, meta_ok, strobe_bad;
    logic        rd_mem;
    logic [31:0] q_hold;
    logic [31:0] ram_q;
    logic [3:0]  meta [2**META_AW];
    logic [META_AW-1:0] meta_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= NAME_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        close      = 1'b0;
        if (!fsAccess) begin
            state_next = NAME_IDLE;
        end else begin
            case (state)
                NAME_IDLE:    if (fsFilename != '0) state_next = NAME_COLLECT;
                NAME_COLLECT: if (fsFilename == '0) begin
                    state_next = NAME_IDLE;
                    close      = 1'b1;
                end
                default:      state_next = NAME_IDLE;
            endcase
        end
        open_next = close ? decode_name(chunk[0], chunk[1], chunk[2], cnt, ovf) : open_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ovf   <= 1'b0;
            chunk <= '{default: '0};
        end else if (!fsAccess || close) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (fsFilename != '0) begin
            if (cnt == 3'd4) begin
                ovf <= 1'b1;
            end else begin
                chunk[cnt[1:0]] <= fsFilename;
                cnt             <= cnt + 3'd1;
            end
        end
    end

    // Strobes see the file opened by a terminator sampled on the same edge.
    assign acc_rd     = fsAccess & fsRden;
    assign acc_wr     = fsAccess & fsWren;
    assign mem_ok     = (open_next == OPEN_MEM)  && ((fsAddress >> MEM_AW)  == 32'd0);
    assign meta_ok    = (open_next == OPEN_META) && ((fsAddress >> META_AW) == 32'd0);
    assign strobe_bad = (acc_rd | acc_wr) && !(mem_ok || meta_ok);
    assign meta_idx   = fsAddress[META_AW-1:0];

    dev_fs_responder_ram #(.AW(MEM_AW), .DW(32)) u_mem (
        .clk     (clk),
        .a_rd    (acc_rd & mem_ok),
        .a_we    (acc_wr & mem_ok),
        .a_addr  (fsAddress[MEM_AW-1:0]),
        .a_wdata (fsData),
        .a_q     (ram_q)
    );

    always_ff @(posedge clk) begin
        if (acc_wr && meta_ok)
            meta[meta_idx] <= fsData[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q   <= OPEN_NONE;
            nameErr  <= 1'b0;
            rangeErr <= 1'b0;
            rd_mem   <= 1'b0;
            q_hold   <= '0;
        end else begin
            open_q   <= open_next;
            nameErr  <= close && (open_next == OPEN_NONE);
            rangeErr <= strobe_bad;
            if (acc_rd) begin
                rd_mem <= mem_ok;
                q_hold <= meta_ok ? {28'd0, meta[meta_idx]} : '0;
            end
        end
    end

    // RAM output is only refreshed on accepted /dev/mem reads, so it holds like q_hold.
    assign fsQ      = rd_mem ? ram_q : q_hold;
    assign openFile = open_q;

endmodule

// File: tb/tb_dev_fs_responder.sv
// Self-checking bench for dev_fs_responder: directed vector table, reset
// sequences, and randomized name/strobe episodes against a behavioural model.
module tb_dev_fs_responder;

    localparam int unsigned MEM_AW  = 12;
    localparam int unsigned META_AW = 4;
    localparam logic [31:0] DEV  = 32'h2F646576;
    localparam logic [31:0] MEMC = 32'h2F6D656D;
    localparam logic [31:0] META = 32'h6D657461;
    localparam logic [31:0] FOO  = 32'h2F666F6F;
    localparam logic [31:0] OOR  = 32'd1 << MEM_AW;
    localparam logic [31:0] MOOR = 32'd1 << META_AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fsAccess, fsRden, fsWren;
    logic [31:0] fsFilename, fsAddress, fsData;
    logic [31:0] fsQ;
    logic [1:0]  openFile;
    logic        nameErr, rangeErr;

    int n_tests = 0;
    int n_fail  = 0;

    dev_fs_responder #(.MEM_AW(MEM_AW), .META_AW(META_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fsAccess   (fsAccess),
        .fsFilename (fsFilename),
        .fsRden     (fsRden),
        .fsWren     (fsWren),
        .fsAddress  (fsAddress),
        .fsData     (fsData),
        .fsQ        (fsQ),
        .openFile   (openFile),
        .nameErr    (nameErr),
        .rangeErr   (rangeErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          acc;
        logic [31:0] fn;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  eo;
        bit          en;
        bit          er;
        logic [31:0] eq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int acc, input logic [31:0] fn, input int rd, input int wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                input int eo, input int en, input int er, input logic [31:0] eq);
        vec_t v;
        v.acc = (acc != 0); v.fn = fn; v.rd = (rd != 0); v.wr = (wr != 0);
        v.addr = addr; v.data = data;
        v.eo = 2'(eo); v.en = (en != 0); v.er = (er != 0); v.eq = eq;
        return v;
    endfunction

    // Reference model: the name is just the list of chunks since the last
    // terminator; storage is a sparse map of written words.
    logic [31:0] m_name[$];
    int unsigned m_open;
    logic [31:0] m_q;
    bit          m_nerr, m_rerr;
    logic [31:0] m_mem  [int unsigned];
    logic [3:0]  m_meta [int unsigned];

    function automatic void model_reset();
        m_name.delete();
        m_open = 0; m_q = '0; m_nerr = 0; m_rerr = 0;
    endfunction

    function automatic void model_step(input bit acc, input logic [31:0] fn, input bit rd, input bit wr,
                                       input logic [31:0] addr, input logic [31:0] data);
        bit ok;
        m_nerr = 0;
        m_rerr = 0;
        if (!acc) begin
            m_name.delete();
            return;
        end
        if (fn != 0) begin
            m_name.push_back(fn);
        end else if (m_name.size() > 0) begin
            if (m_name.size() == 2 && m_name[0] == DEV && m_name[1] == MEMC)
                m_open = 1;
            else if (m_name.size() == 3 && m_name[0] == DEV && m_name[1] == MEMC && m_name[2] == META)
                m_open = 2;
            else begin
                m_open = 0;
                m_nerr = 1;
            end
            m_name.delete();
        end
        ok = (m_open == 1 && addr < OOR) || (m_open == 2 && addr < MOOR);
        if (rd) begin
            if (!ok)
                m_q = '0;
            else if (m_open == 1)
                m_q = m_mem.exists(addr) ? m_mem[addr] : '0;
            else
                m_q = {28'd0, (m_meta.exists(addr) ? m_meta[addr] : 4'd0)};
        end
        if (wr && ok) begin
            if (m_open == 1) m_mem[addr] = data;
            else             m_meta[addr] = data[3:0];
        end
        if ((rd || wr) && !ok)
            m_rerr = 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] eo, input bit en, input bit er,
                              input logic [31:0] eq);
        check({tag, " openFile"}, {30'd0, openFile}, {30'd0, eo});
        check({tag, " nameErr"},  {31'd0, nameErr},  {31'd0, en});
        check({tag, " rangeErr"}, {31'd0, rangeErr}, {31'd0, er});
        check({tag, " fsQ"},      fsQ,               eq);
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, 2'(m_open), m_nerr, m_rerr, m_q);
    endtask

    task automatic drive(input int acc, input logic [31:0] fn, input int rd, input int wr,
                         input logic [31:0] addr, input logic [31:0] data);
        fsAccess = (acc != 0); fsFilename = fn; fsRden = (rd != 0); fsWren = (wr != 0);
        fsAddress = addr; fsData = data;
        model_step(acc != 0, fn, rd != 0, wr != 0, addr, data);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return OOR;
            1:       return 32'hFFFF_FFFF;
            2:       return MOOR + 32'($urandom_range(0, 3));
            default: return 32'($urandom_range(0, 19));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] seq[$];
    int          kind;

    initial begin
        rst_n = 1'b0;
        fsAccess = 1'b0; fsFilename = '0; fsRden = 1'b0; fsWren = 1'b0;
        fsAddress = '0; fsData = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("reset", 2'd0, 1'b0, 1'b0, 32'd0);

        //          acc fn    rd wr addr  data          open nE rE fsQ
        vecs.push_back(mk(1, DEV,  0, 0, 0,    0,            0, 0, 0, 0));
        vecs.push_back(mk(1, MEMC, 0, 0, 0,    0,            0, 0, 0, 0));
        vecs.push_back(mk(1, 0,    0, 0, 0,    0,            1, 0, 0, 0));
        vecs.push_back(mk(1, 0,    0, 1, 5,    32'hDEADBEEF, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,    1, 0, 5,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0,    0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0,    0, 1, 0,    32'h11111111, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0,    0, 1, OOR,  32'h12345678, 1, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0,    1, 0, 0,    0,            1, 0, 0, 32'h11111111));
        vecs.push_back(mk(1, 0,    1, 0, OOR,  0,            1, 0, 1, 0));
        vecs.push_back(mk(1, 0,    0, 1, 7,    1,            1, 0, 0, 0));
        vecs.push_back(mk(1, 0,    1, 1, 7,    2,            1, 0, 0, 1));
        vecs.push_back(mk(1, 0,    1, 0, 7,    0,            1, 0, 0, 2));
        vecs.push_back(mk(1, 0,    1, 0, 5,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, DEV,  0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, MEMC, 0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, META, 0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0,    0, 1, 3,    32'hFFFFFFFA, 2, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0,    1, 0, 3,    0,            2, 0, 0, 32'h0000000A));
        vecs.push_back(mk(1, 0,    1, 0, MOOR, 0,            2, 0, 1, 0));
        vecs.push_back(mk(1, DEV,  0, 0, 0,    0,            2, 0, 0, 0));
        vecs.push_back(mk(1, FOO,  0, 0, 0,    0,            2, 0, 0, 0));
        vecs.push_back(mk(1, 0,    0, 0, 0,    0,            0, 1, 0, 0));
        vecs.push_back(mk(1, 0,    1, 0, 5,    0,            0, 0, 1, 0));
        vecs.push_back(mk(0, 0,    1, 1, 5,    0,            0, 0, 0, 0));
        vecs.push_back(mk(1, DEV,  0, 0, 0,    0,            0, 0, 0, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0,    0,            0, 0, 0, 0));
        vecs.push_back(mk(1, MEMC, 0, 0, 0,    0,            0, 0, 0, 0));
        vecs.push_back(mk(1, 0,    0, 0, 0,    0,            0, 1, 0, 0));
        vecs.push_back(mk(1, DEV,  0, 0, 0,    0,            0, 0, 0, 0));
        vecs.push_back(mk(1, MEMC, 0, 0, 0,    0,            0, 0, 0, 0));
        vecs.push_back(mk(1, 0,    0, 0, 0,    0,            1, 0, 0, 0));
        vecs.push_back(mk(1, 0,    0, 0, 0,    0,            1, 0, 0, 0));
        vecs.push_back(mk(1, 0,    1, 0, 5,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, DEV,  0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, MEMC, 0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, META, 0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, META, 0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, META, 0, 0, 0,    0,            1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0,    1, 0, 5,    0,            0, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].acc, vecs[i].fn, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
            check_outs($sformatf("vec%0d", i), vecs[i].eo, vecs[i].en, vecs[i].er, vecs[i].eq);
        end

        // Asynchronous reset in the middle of a pending read.
        drive(1, DEV, 0, 0, 0, 0);
        drive(1, MEMC, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("reopen openFile", {30'd0, openFile}, 32'd1);
        drive(1, 0, 1, 0, 5, 0);
        check("pre-reset fsQ", fsQ, 32'hDEADBEEF);
        fsRden = 1'b1; fsAddress = 32'd5;
        #2 rst_n = 1'b0;
        #1;
        check("async openFile", {30'd0, openFile}, 32'd0);
        check("async fsQ", fsQ, 32'd0);
        fsRden = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        #1;
        check("in-reset fsQ", fsQ, 32'd0);
        drive(1, 0, 1, 0, 5, 0);
        check("post-reset rangeErr", {31'd0, rangeErr}, 32'd1);
        check_model("post-reset");

        // Reset between the two name chunks discards the first one.
        drive(1, DEV, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        drive(1, MEMC, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("split-name nameErr", {31'd0, nameErr}, 32'd1);
        check("split-name openFile", {30'd0, openFile}, 32'd0);
        check_model("split-name");

        // Fill both stores with known data, then run random episodes.
        drive(1, DEV, 0, 0, 0, 0); check_model("init");
        drive(1, MEMC, 0, 0, 0, 0); check_model("init");
        drive(1, 0, 0, 0, 0, 0); check_model("init");
        for (int a = 0; a < 20; a++) begin
            drive(1, 0, 0, 1, 32'(a), $urandom());
            check_model("init_mem");
        end
        drive(1, DEV, 0, 0, 0, 0); check_model("init");
        drive(1, MEMC, 0, 0, 0, 0); check_model("init");
        drive(1, META, 0, 0, 0, 0); check_model("init");
        drive(1, 0, 0, 0, 0, 0); check_model("init");
        for (int a = 0; a < 16; a++) begin
            drive(1, 0, 0, 1, 32'(a), $urandom());
            check_model("init_meta");
        end

        for (int ep = 0; ep < 150; ep++) begin
            kind = int'($urandom_range(0, 4));
            seq.delete();
            case (kind)
                0: seq = '{DEV, MEMC};
                1: seq = '{DEV, MEMC, META};
                2: seq = '{DEV, FOO};
                3: seq = '{DEV, MEMC, META, META, MEMC};
                default: begin
                    for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                        seq.push_back(($urandom_range(0, 1) != 0) ? MEMC : $urandom());
                end
            endcase
            for (int j = 0; j <= int'($urandom_range(0, 3)); j++)
                seq.push_back(32'd0);
            for (int j = 0; j < seq.size(); j++) begin
                drive(($urandom_range(0, 19) != 0) ? 1 : 0, seq[j],
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      rand_addr(), $urandom());
                check_model($sformatf("rnd%0d", ep));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dev_fs_responder.md
DEV_FS_RESPONDER -- requirements
Module: dev_fs_responder

Interface
REQ-001 Parameter MEM_AW, default 12, word-address width of the /dev/mem backing store (2^MEM_AW words of 32 bits).
REQ-002 Parameter META_AW, default 4, entry-address width of the /dev/memmeta store (2^META_AW entries of 4 bits).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 fsAccess  input  1  initiator owns the filesystem port this cycle.
REQ-007 fsFilename  input  32  filename chunk, 4 ASCII bytes big-endian; 0 = terminator.
REQ-008 fsRden, fsWren  input  1 each  read / write strobe.
REQ-009 fsAddress, fsData  input  32 each  word address and write data.
REQ-010 fsQ  output  32  read data.
REQ-011 openFile  output  2  0 = none, 1 = /dev/mem, 2 = /dev/memmeta.
REQ-012 nameErr, rangeErr  output  1 each  one-cycle error pulses.

Function
REQ-013 All inputs are ignored while fsAccess is low, except that a low fsAccess clears the name buffer; openFile is retained.
REQ-014 Name states: IDLE (no chunks) -> COLLECT on a nonzero chunk; COLLECT appends each nonzero chunk into a 4-chunk (128-bit) buffer.
REQ-015 A zero chunk in COLLECT closes the name: "/dev"+"/mem" sets openFile=1, "/dev"+"/mem"+"meta" sets openFile=2, any other name sets openFile=0 and pulses nameErr; the state returns to IDLE.
REQ-016 A fifth nonzero chunk marks overflow; the next terminator yields openFile=0 and nameErr.
REQ-017 A zero chunk in IDLE is a no-op.
REQ-018 openFile updates on the clock edge that samples the terminator; a strobe in that same cycle applies to the newly opened file.
REQ-019 fsWren with openFile=1 and fsAddress < 2^MEM_AW writes fsData to word fsAddress[MEM_AW-1:0].
REQ-020 fsWren with openFile=2 and fsAddress < 2^META_AW writes fsData[3:0] to the metadata entry.
REQ-021 fsRden returns the addressed word on fsQ exactly one cycle after the strobe edge; metadata reads are zero-extended.
REQ-022 fsQ holds its value until the next accepted read.
REQ-023 An out-of-range address drops the write, returns 0 for a read, and pulses rangeErr one cycle after the strobe.
REQ-024 A strobe with openFile=0 is dropped, returns 0 for a read, and pulses rangeErr.
REQ-025 When fsRden and fsWren are both set, the write is performed and the read returns the pre-write contents (read-before-write).
REQ-026 Back-to-back reads are accepted every cycle with no bubbles.

Reset
REQ-027 rst_n low asynchronously forces the name state to IDLE, clears the name buffer and overflow flag, and sets openFile=0, fsQ=0, nameErr=0, rangeErr=0.
REQ-028 Storage contents are not reset.
REQ-029 Reset asserted mid-name or mid-read discards the operation; the first post-reset strobe without a new open is dropped per REQ-024.

Structure
REQ-030 Path constants (32'h2F646576 "/dev", 32'h2F6D656D "/mem", 32'h6D657461 "meta") and openFile encodings belong in a shared package.
REQ-031 The /dev/mem store instantiates the existing RAM sub-module #(MEM_AW, 32) using port a only; the metadata store is a local register array.

Verification
REQ-032 Send chunks "/dev", "/mem", 0, then write 32'hDEADBEEF to address 5, then read address 5 -> openFile=1 after the terminator; fsQ=32'hDEADBEEF one cycle after the read.
REQ-033 Send "/dev", "/mem", "meta" and, in the terminator cycle, write 4'hA to address 3; then read address 3 -> openFile=2; fsQ=32'h0000000A.
REQ-034 Send "/dev", "/foo", 0 -> openFile=0 and one nameErr pulse; a subsequent read returns 0 with rangeErr.
REQ-035 With /dev/mem open, read address 2^MEM_AW -> fsQ=0 and rangeErr; a write to 2^MEM_AW leaves word 0 unchanged.
REQ-036 Word 7 = 1; apply fsRden and fsWren (data 2) to address 7 in the same cycle, then read address 7 -> first fsQ=1, second fsQ=2.
REQ-037 Assert rst_n low between "/dev" and "/mem", then send "/mem", 0 -> nameErr; openFile=0.
